// File: rtl/operation_uart_tx.sv
// UART transmitter fed by a small byte FIFO; 8N1 frames, or 8E1 when
// OPERATION_UART_TX_PARITY_EN is defined.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   pi_data  - byte from the upstream stage
//   pi_flag  - one-cycle strobe qualifying pi_data
//   po_tx    - registered serial line, idle high
//   po_busy  - high while a frame is on the line
//   po_ovf   - sticky: a strobed byte was dropped
//   po_cnt   - FIFO occupancy
module operation_uart_tx #(
    parameter int BAUD_DIV = 434,
    parameter int FIFO_AW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       pi_data,
    input  logic             pi_flag,
    output logic             po_tx,
    output logic             po_busy,
    output logic             po_ovf,
    output logic [FIFO_AW:0] po_cnt
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef OPERATION_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic tx_q, tx_d;
    logic ovf_q, ovf_d;
    logic [FIFO_AW:0] cnt_q, cnt_d;
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [7:0] mem [DEPTH];

    logic done, empty, full, pop, wr;

    assign done  = (baud_q == BAUD_LAST);
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);

    // A pop in the same cycle frees a slot, so a strobe into a full
    // FIFO is still accepted then.
    assign wr = pi_flag && (!full || pop);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        pop     = 1'b0;
        // Baud counter restarts on every bit boundary and state entry.
        baud_d  = (state_q == IDLE || done) ? 16'd0 : baud_q + 16'd1;

        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    data_d  = mem[rptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (done) begin
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (done) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef OPERATION_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef OPERATION_UART_TX_PARITY_EN
            PARITY: begin
                if (done) state_d = STOP;
            end
`endif
            STOP: begin
                if (done) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        data_d  = mem[rptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line value for the upcoming cycle, so po_tx lines up with state.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[idx_d];
`ifdef OPERATION_UART_TX_PARITY_EN
            PARITY:  tx_d = ^data_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wptr_d = wr  ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        ovf_d  = ovf_q | (pi_flag & full & ~pop);
        unique case ({wr, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr_q] <= pi_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    assign po_tx   = tx_q;
    assign po_busy = (state_q != IDLE);
    assign po_ovf  = ovf_q;
    assign po_cnt  = cnt_q;

endmodule

// File: tb/tb_operation_uart_tx.sv
// Bench for operation_uart_tx: random strobes, queue-based line model,
// serial-line decoder that checks every frame against the model.
module tb_operation_uart_tx;

    localparam int BAUD  = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
`ifdef OPERATION_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = BAUD * NBITS;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pi_flag = 1'b0;
    logic [7:0] pi_data = 8'h00;
    logic po_tx, po_busy, po_ovf;
    logic [AW:0] po_cnt;

    operation_uart_tx #(.BAUD_DIV(BAUD), .FIFO_AW(AW)) dut (
        .clk(clk), .reset(reset), .pi_data(pi_data), .pi_flag(pi_flag),
        .po_tx(po_tx), .po_busy(po_busy), .po_ovf(po_ovf), .po_cnt(po_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: a byte queue plus "cycles left in current frame".
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int rem = 0;
    bit m_ovf = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            fq.delete();
            exp_q.delete();
            rem = 0;
            m_ovf = 1'b0;
        end else begin
            bit pop_now, acc;
            pop_now = (fq.size() > 0) && (rem <= 1);
            acc = 1'b0;
            if (pi_flag) begin
                if (fq.size() < DEPTH || pop_now) acc = 1'b1;
                else m_ovf = 1'b1;
            end
            if (pop_now) begin
                exp_q.push_back(fq.pop_front());
                rem = FRAME;
            end else if (rem > 0) begin
                rem--;
            end
            if (acc) fq.push_back(pi_data);
        end
    end

    // Status checks and serial decoder.
    bit mon_active = 1'b0;
    int mon_cyc = 0;
    logic bits [NBITS];

    always @(negedge clk) begin
        if (!reset) begin
            mon_active = 1'b0;
        end else begin
            chk("po_cnt", int'(po_cnt), fq.size());
            chk("po_ovf", int'(po_ovf), int'(m_ovf));
            chk("po_busy", int'(po_busy), int'(rem > 0));
            if (!mon_active && po_tx == 1'b0) begin
                mon_active = 1'b1;
                mon_cyc = 0;
            end
            if (mon_active) begin
                int bi;
                bi = mon_cyc / BAUD;
                if (mon_cyc % BAUD == 0) bits[bi] = po_tx;
                else chk("bit_stable", int'(po_tx), int'(bits[bi]));
                mon_cyc++;
                if (mon_cyc == FRAME) begin
                    logic [7:0] d, e;
                    mon_active = 1'b0;
                    for (int i = 0; i < 8; i++) d[i] = bits[1 + i];
                    chk("start_bit", int'(bits[0]), 0);
                    chk("stop_bit", int'(bits[NBITS-1]), 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", int'(d), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", int'(d), int'(e));
`ifdef OPERATION_UART_TX_PARITY_EN
                        chk("parity", int'(bits[9]), int'(^e));
`endif
                    end
                end
            end
        end
    end

    task automatic drive(input logic f, input logic [7:0] d);
        @(negedge clk);
        pi_flag = f;
        pi_data = d;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(rem == 0 && fq.size() == 0 && !mon_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(n < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rem(input int r, input int budget);
        int n = 0;
        while (rem != r && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("rem_timeout", int'(n < budget), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int bc, peak;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tx", int'(po_tx), 1);
        chk("rst_busy", int'(po_busy), 0);
        chk("rst_ovf", int'(po_ovf), 0);
        chk("rst_cnt", int'(po_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        // Single byte, frame length
        drive(1'b1, 8'h5A);
        drive(1'b0, 8'h00);
        bc = 0;
        repeat (FRAME + 20) begin
            @(negedge clk);
            if (po_busy) bc++;
        end
        chk("busy_cycles", bc, FRAME);
        wait_idle(200);

        // Two bytes, parity 0 and 1 when enabled
        drive(1'b1, 8'h5A);
        drive(1'b1, 8'h07);
        drive(1'b0, 8'h00);
        wait_idle(400);

        // Overflow burst
        peak = 0;
        for (int i = 1; i <= 6; i++) drive(1'b1, 8'(i));
        drive(1'b0, 8'h00);
        chk("ovf_set", int'(po_ovf), 1);
        repeat (FRAME * 6) begin
            @(negedge clk);
            if (int'(po_cnt) > peak) peak = int'(po_cnt);
        end
        chk("cnt_peak", peak, 4);
        wait_idle(1000);
        chk("ovf_sticky", int'(po_ovf), 1);

        // Strobe into full FIFO in the STOP-end pop cycle
        do_reset();
        for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i));
        drive(1'b0, 8'h00);
        chk("full_cnt", int'(po_cnt), 4);
        wait_rem(1, 200);
        pi_flag = 1'b1;
        pi_data = 8'hC3;
        @(negedge clk);
        pi_flag = 1'b0;
        chk("simul_ovf", int'(po_ovf), 0);
        chk("simul_cnt", int'(po_cnt), 4);
        wait_idle(1000);

        // Reset in the middle of DATA bit 3
        drive(1'b1, 8'hFF);
        drive(1'b0, 8'h00);
        wait_rem(FRAME - 18, 200);
        #2 reset = 1'b0;
        #1;
        chk("midrst_tx", int'(po_tx), 1);
        chk("midrst_busy", int'(po_busy), 0);
        chk("midrst_cnt", int'(po_cnt), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bc = 0;
        repeat (100) begin
            @(negedge clk);
            if (po_busy || !po_tx) bc++;
        end
        chk("no_restart", bc, 0);

        // Random traffic: sparse, then dense enough to overflow
        do_reset();
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 11) == 0), 8'($urandom));
        for (int i = 0; i < 200; i++)
            drive(1'($urandom_range(0, 1)), 8'($urandom));
        drive(1'b0, 8'h00);
        wait_idle(3000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
